led_msg_scroller: RTL and testbench
===================================

# led_msg_scroller

Scrolling-message source for the four-digit seven-segment display path. It holds a 16-character message of 4-bit hex codes, loaded through a simple write port. It periodically produces a four-character window of that message and presents it to the display driver's character input over a valid/ready handshake. It sits upstream of the multiplexed display driver and its decoder, on the same divided display clock.

## Interface
- SCROLL_DIV, 50000, cycles spent in COUNT between an accepted frame and the next fetch; legal range 1 to 2^24-1
- CNT_W, 24, width of the scroll timer
- clk  in  1  display-domain clock
- reset  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe for message memory
- wr_addr  in  4  message index to write
- wr_data  in  4  character code to write
- run  in  1  scrolling enable
- disp_ready  in  1  driver accepts the current frame
- disp_valid  out  1  disp_chars holds a frame
- disp_chars  out  16  window; [15:12]=an3 (leftmost) char, [3:0]=an0 char
- pos  out  4  message index of the leftmost character of the next or current frame
- busy  out  1  high in any state except IDLE

## Operation
- Memory: 16x4 registers, all cleared to 4'h0 by reset. A write with wr_en=1 takes effect at the clock edge, in any state.
- Window: chars mem[pos], mem[pos+1], mem[pos+2], mem[pos+3], with indices taken mod 16. mem[pos] goes to [15:12].
- FSM states: IDLE, COUNT, FETCH, PRESENT.
- IDLE: if run=1, go to FETCH with fidx=0; otherwise stay.
- FETCH: each cycle, load mem[pos+fidx] into the window register slot fidx. fidx increments each cycle.
  - If run=0 in any FETCH cycle, abort to IDLE. disp_valid never rises, and pos is unchanged.
  - After the fidx=3 cycle, go to PRESENT.
- PRESENT: disp_valid=1 and disp_chars is held stable.
  - On disp_valid & disp_ready: pos <= pos+1 (wraps 15 to 0), clear the timer, go to COUNT.
  - run is ignored in PRESENT. A frame once offered is never withdrawn.
- COUNT: the timer increments each cycle.
  - When the timer reaches SCROLL_DIV-1, go to FETCH with fidx=0.
  - If run=0, go to IDLE immediately and clear the timer. pos is held, so scrolling resumes at the same pos.
- Write collisions:
  - A write to an address read in the same FETCH cycle returns the old data (read-before-write).
  - A write during PRESENT never alters disp_chars. The new data appears in a later frame.
- busy=1 in COUNT, FETCH and PRESENT.

## Timing
- Reset values: state=IDLE, disp_valid=0, disp_chars=16'h0000, pos=0, busy=0, timer=0, fidx=0, memory all 0.
- Reset wins over every other event in the same cycle, including an accepting handshake and a write.
- Start latency: run first sampled 1 in IDLE at cycle t. FETCH occupies t+1..t+4, and disp_valid=1 from cycle t+5.
- Frame period: with acceptance at cycle a:
  - COUNT occupies a+1..a+SCROLL_DIV.
  - FETCH occupies a+SCROLL_DIV+1..a+SCROLL_DIV+4.
  - disp_valid rises at a+SCROLL_DIV+5.
  - With disp_ready tied high, the period is SCROLL_DIV+5 cycles.
- Acceptance cycle and after: disp_valid stays 1 during the acceptance cycle and drops to 0 in cycle a+1. pos shows the new value from a+1.
- Backpressure: disp_ready may stay low indefinitely. disp_valid, disp_chars and pos stay constant and the timer does not run.
- disp_chars changes only at the edge entering PRESENT. Between frames it holds the last frame.
- Timer width: the timer is CNT_W bits. SCROLL_DIV=1 gives exactly one COUNT cycle.

## Test plan
- Reset: hold reset=0 for 3 cycles while driving run=1, wr_en=1 and disp_ready=1.
  - Required: disp_valid=0, disp_chars=0, pos=0 and busy=0 each cycle.
  - Required: after release with run=0, no frame appears.
- Basic scroll: load mem[i]=i, SCROLL_DIV=4, disp_ready=1, raise run.
  - Required: frames 0x0123, 0x1234, 0x2345 … 0xCDEF, 0xDEF0, 0xEF01, 0xF012, then 0x0123 again.
  - Required: first disp_valid 5 cycles after run, then one frame every 9 cycles.
- Backpressure: during PRESENT showing 0x3456, hold disp_ready=0 for 10 cycles.
  - Required: disp_valid=1, disp_chars=0x3456 and pos=3 stable throughout.
  - Required: the next frame is 0x4567, 9 cycles after acceptance.
- Run drop:
  - In COUNT after frame 0x1234 is accepted, drop run for 7 cycles. Required: busy=0 and no frame during the drop. After run returns, the next frame is 0x2345 after 5 cycles.
  - Drop run during PRESENT. Required: the frame remains offered until accepted.
- Write collision:
  - Write mem[5]=4'hA while frame 0x2345 is in PRESENT. Required: disp_chars stays 0x2345 and the next frame is 0x34A6.
  - Write mem[pos] in the first FETCH cycle. Required: that frame shows the old value.
- Reset mid-operation: assert reset while PRESENT shows 0x789A.
  - Required: the next cycle has disp_valid=0, pos=0 and memory cleared.
  - Required: restarting yields 0x0000.

Source files
------------

// File: rtl/led_msg_scroller.sv
// led_msg_scroller
// Scrolling-message source for the four-digit seven-segment display path.
// Holds a 16-entry message of 4-bit character codes and periodically offers
// a four-character window of it to the display driver over valid/ready.
//
// Ports:
//   clk        display-domain clock
//   reset      synchronous, active-low reset
//   wr_en      message memory write strobe (honoured in every state)
//   wr_addr    message index to write
//   wr_data    character code to write
//   run        scrolling enable
//   disp_ready driver accepts the current frame
//   disp_valid disp_chars holds a frame
//   disp_chars window; [15:12] = leftmost (an3) char, [3:0] = an0 char
//   pos        message index of the leftmost char of the next/current frame
//   busy       high in any state except IDLE
module led_msg_scroller #(
    parameter int unsigned SCROLL_DIV = 50000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        run,
    input  logic        disp_ready,
    output logic        disp_valid,
    output logic [15:0] disp_chars,
    output logic [3:0]  pos,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        FETCH,
        PRESENT
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(SCROLL_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       mem [16];
    logic [3:0]       win [4];
    logic [CNT_W-1:0] timer;
    logic [1:0]       fidx;
    logic [3:0]       rd_char;

    // Registered memory: a read in the same cycle as a write sees old data.
    always_comb begin
        rd_char = mem[pos + {2'b00, fidx}];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        disp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (fidx == 2'd3) begin
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                // run is deliberately ignored: an offered frame is never withdrawn
                disp_valid = 1'b1;
                if (disp_ready) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (timer == TIMER_LAST) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem        <= '{default: '0};
            win        <= '{default: '0};
            timer      <= '0;
            fidx       <= '0;
            pos        <= '0;
            disp_chars <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            case (state)
                IDLE: begin
                    fidx  <= '0;
                    timer <= '0;
                end
                COUNT: begin
                    if (!run) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FETCH: begin
                    win[fidx] <= rd_char;
                    if (!run) begin
                        fidx <= '0;
                    end else begin
                        // fidx wraps 3 -> 0, ready for the next fetch
                        fidx <= fidx + 1'b1;
                        // Last slot goes straight into the output so disp_chars
                        // only changes on the edge entering PRESENT.
                        if (fidx == 2'd3) begin
                            disp_chars <= {win[0], win[1], win[2], rd_char};
                        end
                    end
                end
                PRESENT: begin
                    if (disp_ready) begin
                        pos   <= pos + 1'b1;
                        timer <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_msg_scroller.sv
module tb_led_msg_scroller;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        run = 1'b0;
    logic        disp_ready = 1'b0;
    logic        disp_valid;
    logic [15:0] disp_chars;
    logic [3:0]  pos;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    led_msg_scroller #(
        .SCROLL_DIV(DIV),
        .CNT_W(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .run(run),
        .disp_ready(disp_ready),
        .disp_valid(disp_valid),
        .disp_chars(disp_chars),
        .pos(pos),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        v;
        logic        b;
        logic [3:0]  p;
        logic [15:0] ch;
    } stat_t;

    typedef struct {
        int          c;
        logic [15:0] ch;
        logic [3:0]  p;
    } frame_t;

    stat_t  sq[$];
    frame_t fq[$];

    // Reference model: abstract timeline of the scroller.
    logic [3:0]  m_mem [16];
    logic [3:0]  m_slot [4];
    int          m_pos = 0;
    bit          m_idle = 1;
    bit          m_off = 0;
    int          m_due = 0;
    logic [15:0] m_chars = '0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model consumes the same inputs.
    task automatic step(input bit rs, input bit r, input bit rd,
                        input bit we, input logic [3:0] wa, input logic [3:0] wd);
        int c;
        int k;
        stat_t s;
        frame_t f;
        @(negedge clk);
        reset = ~rs;
        run = r;
        disp_ready = rd;
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        c = cyc;
        if (rs) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_pos = 0;
            m_idle = 1;
            m_off = 0;
            m_chars = '0;
        end else begin
            if (m_off) begin
                if (rd) begin
                    m_off = 0;
                    m_pos = (m_pos + 1) % 16;
                    m_due = c + DIV + 5;
                end
            end else if (m_idle) begin
                if (r) begin
                    m_idle = 0;
                    m_due = c + 5;
                end
            end else if (!r) begin
                m_idle = 1;
            end else if (c >= m_due - 4) begin
                k = c - (m_due - 4);
                m_slot[k] = m_mem[(m_pos + k) % 16];
                if (k == 3) begin
                    m_chars = {m_slot[0], m_slot[1], m_slot[2], m_slot[3]};
                    m_off = 1;
                    f.c = c + 1;
                    f.ch = m_chars;
                    f.p = 4'(m_pos);
                    fq.push_back(f);
                end
            end
            if (we) m_mem[wa] = wd;
        end
        s.c = c + 1;
        s.v = m_off;
        s.b = !m_idle;
        s.p = 4'(m_pos);
        s.ch = m_chars;
        sq.push_back(s);
    endtask

    task automatic wait_off(input int p, input bit r);
        int n;
        n = 0;
        while (!(m_off && m_pos == p) && n < 400) begin
            step(0, r, 1, 0, 4'h0, 4'h0);
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL wait_offer_pos%0d timeout got=none exp=offer", p);
        end
    endtask

    // Monitor: per-cycle status and frame presentation against the model.
    stat_t  ms;
    frame_t mf;
    bit     prev_v = 0;

    always @(posedge clk) begin
        #1;
        if (sq.size() > 0 && sq[0].c == cyc) begin
            ms = sq.pop_front();
            chk("valid", {15'h0, disp_valid}, {15'h0, ms.v});
            chk("busy", {15'h0, busy}, {15'h0, ms.b});
            chk("pos", {12'h0, pos}, {12'h0, ms.p});
            chk("chars", disp_chars, ms.ch);
        end
        if (disp_valid === 1'b1 && !prev_v) begin
            if (fq.size() == 0) begin
                chk("frame_unexpected", disp_chars, 16'hxxxx);
            end else begin
                mf = fq.pop_front();
                chk("frame_cycle", 16'(cyc), 16'(mf.c));
                chk("frame_chars", disp_chars, mf.ch);
                chk("frame_pos", {12'h0, pos}, {12'h0, mf.p});
            end
        end
        prev_v = (disp_valid === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] a;
        foreach (m_mem[i]) m_mem[i] = '0;

        // Reset held with everything else active
        repeat (3) step(1, 1, 1, 1, 4'h3, 4'h5);
        repeat (10) step(0, 0, 0, 0, 4'h0, 4'h0);

        // Load mem[i] = i
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 4'(i), 4'(i));

        // Basic scroll through a full wrap
        repeat (150) step(0, 1, 1, 0, 4'h0, 4'h0);

        // Backpressure on 0x3456
        wait_off(3, 1);
        repeat (10) step(0, 1, 0, 0, 4'h0, 4'h0);
        wait_off(4, 1);

        // Run drop in COUNT after 0x1234 accepted
        wait_off(1, 1);
        step(0, 1, 1, 0, 4'h0, 4'h0);
        step(0, 1, 1, 0, 4'h0, 4'h0);
        repeat (7) step(0, 0, 1, 0, 4'h0, 4'h0);
        wait_off(2, 1);

        // Run drop during PRESENT: frame stays offered
        repeat (5) step(0, 0, 0, 0, 4'h0, 4'h0);
        step(0, 0, 1, 0, 4'h0, 4'h0);
        repeat (4) step(0, 0, 0, 0, 4'h0, 4'h0);

        // Write to mem[5] while 0x2345 is presented
        wait_off(2, 1);
        step(0, 1, 0, 1, 4'h5, 4'hA);
        repeat (2) step(0, 1, 0, 0, 4'h0, 4'h0);
        wait_off(3, 1);

        // Write mem[pos] in the first FETCH cycle
        n = 0;
        while (!(!m_off && !m_idle && (cyc + 1 == m_due - 4)) && n < 100) begin
            step(0, 1, 1, 0, 4'h0, 4'h0);
            n++;
        end
        a = 4'(m_pos);
        step(0, 1, 1, 1, a, ~m_mem[a]);
        wait_off((m_pos + 1) % 16, 1);

        // Reset while 0x789A is presented, then restart
        wait_off(7, 1);
        step(1, 1, 1, 1, 4'h7, 4'hF);
        repeat (3) step(0, 0, 0, 0, 4'h0, 4'h0);
        wait_off(0, 1);
        step(0, 1, 1, 0, 4'h0, 4'h0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        // Drain
        repeat (20) step(0, 0, 1, 0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        chk("frames_pending", 16'(fq.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
